mem_port_arbiter: RTL and testbench

- Shares the single processor memory port (READ/WRITE, address, data) between two requesters: instruction fetch (IF, requester 0) and data load/store (DM, requester 1).
- Sits between the control-unit/datapath memory interface and the memory model.
- Sequences each access as grant, then a fixed-latency memory cycle, then a completion pulse.
- Arbitrates simultaneous requests round-robin.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_rr2.sv | 28 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, requester IDs and default bus widths.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   localparam logic ARB_IF = 1'b0;
   localparam logic ARB_DM = 1'b1;

   localparam int ADDR_W_DEF = 26;
   localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// Two-way round-robin pick. The pointer only moves on a contested pick,
// so a lone requester never steals the next turn from the other side.
module arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       update,
   output logic       winner
);

   logic prio;

   // A lone request wins outright; req[1] selects DM when only DM asks.
   always_comb begin
      winner = (req == 2'b11) ? prio : req[1];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prio <= ARB_IF;
      end else if (update) begin
         prio <= ~winner;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access:
// grant, a fixed LATENCY-cycle strobe, then a one-cycle completion pulse.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LATENCY = 2
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_DONE,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [ADDR_W-1:0] DM_ADDR,
   input  logic [DATA_W-1:0] DM_WDATA,
   output logic              DM_GNT,
   output logic              DM_DONE,
   output logic [DATA_W-1:0] RDATA,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output arb_state_t        ARB_STATE
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   arb_state_t state;
   logic [3:0] cnt;
   logic       we;
   logic       owner;
   logic       winner;
   logic       rr_update;

   assign rr_update = (state == ARB_IDLE) && IF_REQ && DM_REQ;
   assign ARB_STATE = state;

   arb_rr2 u_rr (
      .CLK    (CLK),
      .RST    (RST),
      .req    ({DM_REQ, IF_REQ}),
      .update (rr_update),
      .winner (winner)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ARB_IDLE;
         cnt       <= '0;
         we        <= 1'b0;
         owner     <= ARB_IF;
         IF_GNT    <= 1'b0;
         IF_DONE   <= 1'b0;
         DM_GNT    <= 1'b0;
         DM_DONE   <= 1'b0;
         RDATA     <= '0;
         MEM_READ  <= 1'b0;
         MEM_WRITE <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (IF_REQ || DM_REQ) begin
                  owner <= winner;
                  cnt   <= CNT_LOAD;
                  state <= ARB_ACCESS;
                  if (winner == ARB_DM) begin
                     MEM_ADDR  <= DM_ADDR;
                     MEM_WDATA <= DM_WDATA;
                     we        <= DM_WE;
                     MEM_READ  <= !DM_WE;
                     MEM_WRITE <= DM_WE;
                     DM_GNT    <= 1'b1;
                  end else begin
                     MEM_ADDR  <= IF_ADDR;
                     we        <= 1'b0;
                     MEM_READ  <= 1'b1;
                     MEM_WRITE <= 1'b0;
                     IF_GNT    <= 1'b1;
                  end
               end
            end
            ARB_ACCESS: begin
               IF_GNT <= 1'b0;
               DM_GNT <= 1'b0;
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Memory data is only valid in the final strobe cycle.
                  if (!we) begin
                     RDATA <= MEM_RDATA;
                  end
                  IF_DONE   <= (owner == ARB_IF);
                  DM_DONE   <= (owner == ARB_DM);
                  MEM_READ  <= 1'b0;
                  MEM_WRITE <= 1'b0;
                  state     <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               IF_DONE <= 1'b0;
               DM_DONE <= 1'b0;
               state   <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LATENCY=2 instance checked by a
// scoreboard on every completion, plus a LATENCY=1 instance for pacing.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int AW = 26;
   localparam int DW = 32;
   localparam int EW = 2 + AW + DW + DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // LATENCY = 2 instance
   logic          if_req_a, if_gnt_a, if_done_a;
   logic [AW-1:0] if_addr_a;
   logic          dm_req_a, dm_we_a, dm_gnt_a, dm_done_a;
   logic [AW-1:0] dm_addr_a;
   logic [DW-1:0] dm_wdata_a, rdata_a, mem_wdata_a, mem_rdata_a;
   logic          mem_read_a, mem_write_a;
   logic [AW-1:0] mem_addr_a;
   arb_state_t    state_a;

   // LATENCY = 1 instance
   logic          if_req_b, if_gnt_b, if_done_b;
   logic [AW-1:0] if_addr_b;
   logic          dm_gnt_b, dm_done_b;
   logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
   logic          mem_read_b, mem_write_b;
   logic [AW-1:0] mem_addr_b;
   arb_state_t    state_b;

   int checks   = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];

   function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
      if (a == 26'h4) return 32'hDEADBEEF;
      return {6'h0, a} ^ 32'h5A5A0000;
   endfunction

   function automatic logic [EW-1:0] mk_exp(input logic id, input logic we,
         input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
      return {id, we, addr, wdata, rd};
   endfunction

   assign mem_rdata_a = rd_pattern(mem_addr_a);
   assign mem_rdata_b = rd_pattern(mem_addr_b);

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) dut_a (
      .CLK(clk), .RST(rst),
      .IF_REQ(if_req_a), .IF_ADDR(if_addr_a), .IF_GNT(if_gnt_a), .IF_DONE(if_done_a),
      .DM_REQ(dm_req_a), .DM_WE(dm_we_a), .DM_ADDR(dm_addr_a), .DM_WDATA(dm_wdata_a),
      .DM_GNT(dm_gnt_a), .DM_DONE(dm_done_a), .RDATA(rdata_a),
      .MEM_READ(mem_read_a), .MEM_WRITE(mem_write_a), .MEM_ADDR(mem_addr_a),
      .MEM_WDATA(mem_wdata_a), .MEM_RDATA(mem_rdata_a), .ARB_STATE(state_a)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut_b (
      .CLK(clk), .RST(rst),
      .IF_REQ(if_req_b), .IF_ADDR(if_addr_b), .IF_GNT(if_gnt_b), .IF_DONE(if_done_b),
      .DM_REQ(1'b0), .DM_WE(1'b0), .DM_ADDR('0), .DM_WDATA('0),
      .DM_GNT(dm_gnt_b), .DM_DONE(dm_done_b), .RDATA(rdata_b),
      .MEM_READ(mem_read_b), .MEM_WRITE(mem_write_b), .MEM_ADDR(mem_addr_b),
      .MEM_WDATA(mem_wdata_b), .MEM_RDATA(mem_rdata_b), .ARB_STATE(state_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (if_gnt_a || dm_gnt_a) ok = 1'b1;
      end
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (if_done_a || dm_done_a) ok = 1'b1;
      end
   endtask

   // Scoreboard monitor for instance A, sampled mid-cycle.
   int            run_len = 0;
   logic [AW-1:0] seen_addr;
   logic [DW-1:0] seen_wdata;
   logic          seen_we;
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst) begin
         run_len = 0;
      end else begin
         check("strobe_exclusive", {63'h0, mem_read_a && mem_write_a}, 64'h0);
         check("gnt_exclusive", {63'h0, if_gnt_a && dm_gnt_a}, 64'h0);
         check("done_exclusive", {63'h0, if_done_a && dm_done_a}, 64'h0);
         if (mem_read_a || mem_write_a) begin
            if (run_len == 0) begin
               seen_addr  = mem_addr_a;
               seen_we    = mem_write_a;
               seen_wdata = mem_wdata_a;
            end
            run_len++;
         end
         if (if_done_a || dm_done_a) begin
            check("done_expected", {63'h0, exp_q.size() != 0}, 64'h1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_id", {63'h0, dm_done_a}, {63'h0, e[EW-1]});
               check("sb_we", {63'h0, seen_we}, {63'h0, e[EW-2]});
               check("sb_addr", {38'h0, seen_addr}, {38'h0, e[EW-3 -: AW]});
               check("sb_strobe_len", 64'(run_len), 64'd2);
               if (e[EW-2]) check("sb_wdata", {32'h0, seen_wdata}, {32'h0, e[2*DW-1 -: DW]});
               check("sb_rdata", {32'h0, rdata_a}, {32'h0, e[DW-1:0]});
            end
            run_len = 0;
         end
      end
   end

   initial begin
      logic ok;
      logic [DW-1:0] last_rd;
      rst = 1'b1;
      if_req_a = 0; if_addr_a = '0; dm_req_a = 0; dm_we_a = 0; dm_addr_a = '0; dm_wdata_a = '0;
      if_req_b = 0; if_addr_b = '0;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_ctrl", {58'h0, if_gnt_a, if_done_a, dm_gnt_a, dm_done_a, mem_read_a, mem_write_a}, 64'h0);
      check("rst_rdata", {32'h0, rdata_a}, 64'h0);
      check("rst_mem_addr", {38'h0, mem_addr_a}, 64'h0);
      check("rst_mem_wdata", {32'h0, mem_wdata_a}, 64'h0);
      check("rst_state", {62'h0, state_a}, {62'h0, ARB_IDLE});

      // Reset in the middle of a DM write: no completion may follow
      dm_req_a = 1; dm_we_a = 1; dm_addr_a = 26'h10; dm_wdata_a = 32'hCAFE0001;
      tick();
      check("abort_gnt", {63'h0, dm_gnt_a}, 64'h1);
      check("abort_write_on", {63'h0, mem_write_a}, 64'h1);
      dm_req_a = 0; dm_we_a = 0;
      #2 rst = 1'b1;
      #1;
      check("abort_write_off", {63'h0, mem_write_a}, 64'h0);
      check("abort_ctrl", {58'h0, if_gnt_a, if_done_a, dm_gnt_a, dm_done_a, mem_read_a, mem_write_a}, 64'h0);
      check("abort_bus", {mem_addr_a, mem_wdata_a, rdata_a}, 64'h0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("abort_no_done", {63'h0, dm_done_a}, 64'h0);

      if_req_a = 1; if_addr_a = 26'h20;
      exp_q.push_back(mk_exp(ARB_IF, 1'b0, 26'h20, 32'h0, rd_pattern(26'h20)));
      tick();
      check("post_rst_if_gnt", {63'h0, if_gnt_a}, 64'h1);
      if_req_a = 0;
      wait_done(ok);
      check("post_rst_done_seen", {63'h0, ok}, 64'h1);
      tick();

      // Lone fetch, cycle-exact
      if_req_a = 1; if_addr_a = 26'h004;
      exp_q.push_back(mk_exp(ARB_IF, 1'b0, 26'h004, 32'h0, 32'hDEADBEEF));
      tick();
      check("fetch_c1_gnt", {62'h0, if_gnt_a, mem_read_a}, 64'h3);
      check("fetch_c1_addr", {38'h0, mem_addr_a}, 64'h4);
      if_req_a = 0;
      tick();
      check("fetch_c2", {61'h0, if_gnt_a, mem_read_a, if_done_a}, 64'h2);
      tick();
      check("fetch_c3", {62'h0, if_done_a, mem_read_a}, 64'h2);
      check("fetch_c3_rdata", {32'h0, rdata_a}, 64'hDEADBEEF);
      tick();

      // Simultaneous requests: IF first, DM in cycle 5
      if_req_a = 1; if_addr_a = 26'h008;
      dm_req_a = 1; dm_we_a = 0; dm_addr_a = 26'h100;
      exp_q.push_back(mk_exp(ARB_IF, 1'b0, 26'h008, 32'h0, rd_pattern(26'h008)));
      exp_q.push_back(mk_exp(ARB_DM, 1'b0, 26'h100, 32'h0, rd_pattern(26'h100)));
      tick();
      check("sim_c1", {62'h0, if_gnt_a, dm_gnt_a}, 64'h2);
      if_req_a = 0;
      tick(); tick(); tick();
      check("sim_c4_no_gnt", {62'h0, if_gnt_a, dm_gnt_a}, 64'h0);
      tick();
      check("sim_c5_dm_gnt", {62'h0, if_gnt_a, dm_gnt_a}, 64'h1);
      dm_req_a = 0;
      wait_done(ok);
      check("sim_done_seen", {63'h0, ok}, 64'h1);

      // Both held again: priority now favours DM
      if_req_a = 1; if_addr_a = 26'h00C;
      dm_req_a = 1; dm_we_a = 0; dm_addr_a = 26'h104;
      exp_q.push_back(mk_exp(ARB_DM, 1'b0, 26'h104, 32'h0, rd_pattern(26'h104)));
      exp_q.push_back(mk_exp(ARB_IF, 1'b0, 26'h00C, 32'h0, rd_pattern(26'h00C)));
      wait_gnt(ok);
      check("rep_first_dm", {61'h0, ok, if_gnt_a, dm_gnt_a}, 64'h5);
      dm_req_a = 0;
      wait_gnt(ok);
      check("rep_second_if", {61'h0, ok, if_gnt_a, dm_gnt_a}, 64'h6);
      if_req_a = 0;
      wait_done(ok);
      check("rep_done_seen", {63'h0, ok}, 64'h1);
      last_rd = rd_pattern(26'h00C);
      tick();

      // DM write leaves RDATA alone
      dm_req_a = 1; dm_we_a = 1; dm_addr_a = 26'h040; dm_wdata_a = 32'h12345678;
      exp_q.push_back(mk_exp(ARB_DM, 1'b1, 26'h040, 32'h12345678, last_rd));
      tick();
      check("wr_c1", {61'h0, dm_gnt_a, mem_write_a, mem_read_a}, 64'h6);
      check("wr_c1_bus", {6'h0, mem_addr_a, mem_wdata_a}, {6'h0, 26'h040, 32'h12345678});
      dm_req_a = 0; dm_we_a = 0;
      tick();
      check("wr_c2", {61'h0, dm_gnt_a, mem_write_a, mem_read_a}, 64'h2);
      tick();
      check("wr_c3", {61'h0, dm_done_a, mem_write_a, mem_read_a}, 64'h4);
      check("wr_rdata_hold", {32'h0, rdata_a}, {32'h0, last_rd});
      tick();

      // DM request arriving during an IF access waits for IDLE
      if_req_a = 1; if_addr_a = 26'h030;
      exp_q.push_back(mk_exp(ARB_IF, 1'b0, 26'h030, 32'h0, rd_pattern(26'h030)));
      exp_q.push_back(mk_exp(ARB_DM, 1'b0, 26'h200, 32'h0, rd_pattern(26'h200)));
      tick();
      check("late_c1_if_gnt", {63'h0, if_gnt_a}, 64'h1);
      if_req_a = 0;
      dm_req_a = 1; dm_we_a = 0; dm_addr_a = 26'h200;
      tick();
      check("late_c2_no_dm", {63'h0, dm_gnt_a}, 64'h0);
      tick();
      check("late_c3", {62'h0, if_done_a, dm_gnt_a}, 64'h2);
      tick();
      check("late_c4_no_dm", {63'h0, dm_gnt_a}, 64'h0);
      tick();
      check("late_c5_dm_gnt", {63'h0, dm_gnt_a}, 64'h1);
      dm_req_a = 0;
      wait_done(ok);
      check("late_done_seen", {63'h0, ok}, 64'h1);
      tick();

      // LATENCY = 1: held fetch repeats every 3 cycles
      if_req_b = 1; if_addr_b = 26'h050;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("l1_gnt_read", {62'h0, if_gnt_b, mem_read_b}, 64'h3);
         check("l1_addr", {38'h0, mem_addr_b}, 64'h50);
         tick();
         check("l1_done", {61'h0, if_gnt_b, mem_read_b, if_done_b}, 64'h1);
         check("l1_rdata", {32'h0, rdata_b}, {32'h0, rd_pattern(26'h050)});
         if (k == 2) if_req_b = 0;
         tick();
         check("l1_idle", {61'h0, if_gnt_b, mem_read_b, if_done_b}, 64'h0);
      end
      repeat (2) tick();
      check("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
